// File: rtl/axis_insert_header_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axis_insert_header_arbiter
//
// Round-robin arbiter that shares a single header-insertion block between
// NUM_SRC frame sources. A source asks for a frame by raising its header valid.
// The winner keeps the grant until its frame is finished. A frame is finished
// once exactly one header has been passed and the payload beat carrying last
// has been accepted. The data paths are pure combinational muxes, and ready
// flows straight back to the granted source, so the data sees no added latency.
//
// Ports (source buses are flattened; source i occupies slice i):
//   clk, rst           clock, synchronous active-high reset
//   s_*_insert         per-source header channel (valid/header/keep/ready)
//   s_*_in             per-source payload channel (valid/data/keep/last/ready)
//   m_*_insert         header channel towards the inserter
//   m_*_in             payload channel towards the inserter
//   grant_id           currently (or most recently) granted source
//   busy               high while a grant is held
// -----------------------------------------------------------------------------
module axis_insert_header_arbiter #(
  parameter int DATA_WD      = 64,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_SRC      = 4,
  parameter int ID_WD        = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic [NUM_SRC-1:0]              s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_header_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert,
  output logic [NUM_SRC-1:0]              s_ready_insert,

  input  logic [NUM_SRC-1:0]              s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in,
  input  logic [NUM_SRC-1:0]              s_last_in,
  output logic [NUM_SRC-1:0]              s_ready_in,

  output logic                            m_valid_insert,
  output logic [DATA_WD-1:0]              m_header_insert,
  output logic [DATA_BYTE_WD-1:0]         m_keep_insert,
  input  logic                            m_ready_insert,

  output logic                            m_valid_in,
  output logic [DATA_WD-1:0]              m_data_in,
  output logic [DATA_BYTE_WD-1:0]         m_keep_in,
  output logic                            m_last_in,
  input  logic                            m_ready_in,

  output logic [ID_WD-1:0]                grant_id,
  output logic                            busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [ID_WD-1:0] ptr, ptr_nxt;
  logic [ID_WD-1:0] grant_nxt;
  logic             hdr_done, hdr_done_nxt;
  logic             last_done, last_done_nxt;

  // ---------------------------------------------------------------------------
  // Round-robin search. The request vector is doubled and shifted right by ptr,
  // so bit k of req_rot is source (ptr + k) mod NUM_SRC. The lowest set bit of
  // req_rot is the first requester in search order.
  // ---------------------------------------------------------------------------
  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   req_rot;
  logic                 req_found;
  logic [ID_WD-1:0]     req_offset;
  logic [ID_WD:0]       req_sum;
  logic [ID_WD-1:0]     req_winner;

  assign req_dbl = {s_valid_insert, s_valid_insert};
  assign req_rot = NUM_SRC'(req_dbl >> ptr);

  // NOTE: every signal written in an always_comb gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_found  = 1'b0;
    req_offset = '0;
    // Walk from high to low so that the lowest set offset is the last write.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        req_found  = 1'b1;
        req_offset = ID_WD'(k);
      end
    end
  end

  // ptr + offset is at most 2*NUM_SRC-2, so one conditional subtract wraps it.
  assign req_sum    = {1'b0, ptr} + {1'b0, req_offset};
  assign req_winner = (req_sum >= (ID_WD+1)'(NUM_SRC))
                    ? ID_WD'(req_sum - (ID_WD+1)'(NUM_SRC))
                    : ID_WD'(req_sum);

  // ---------------------------------------------------------------------------
  // Select the granted source's fields. The compare-per-source form keeps every
  // part-select constant.
  // ---------------------------------------------------------------------------
  logic                    sel_hdr_valid;
  logic [DATA_WD-1:0]      sel_header;
  logic [DATA_BYTE_WD-1:0] sel_hdr_keep;
  logic                    sel_pay_valid;
  logic [DATA_WD-1:0]      sel_data;
  logic [DATA_BYTE_WD-1:0] sel_pay_keep;
  logic                    sel_last;

  always_comb begin
    sel_hdr_valid = 1'b0;
    sel_header    = '0;
    sel_hdr_keep  = '0;
    sel_pay_valid = 1'b0;
    sel_data      = '0;
    sel_pay_keep  = '0;
    sel_last      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == ID_WD'(i)) begin
        sel_hdr_valid = s_valid_insert[i];
        sel_header    = s_header_insert[i*DATA_WD +: DATA_WD];
        sel_hdr_keep  = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        sel_pay_valid = s_valid_in[i];
        sel_data      = s_data_in[i*DATA_WD +: DATA_WD];
        sel_pay_keep  = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        sel_last      = s_last_in[i];
      end
    end
  end

  // A channel is open only while the grant is held and its part of the frame
  // is still outstanding. One header per frame; nothing after the last beat.
  logic hdr_active;
  logic pay_active;

  assign hdr_active = (state == GRANT) && !hdr_done;
  assign pay_active = (state == GRANT) && !last_done;

  assign m_valid_insert  = hdr_active & sel_hdr_valid;
  assign m_header_insert = hdr_active ? sel_header   : '0;
  assign m_keep_insert   = hdr_active ? sel_hdr_keep : '0;

  assign m_valid_in = pay_active & sel_pay_valid;
  assign m_data_in  = pay_active ? sel_data     : '0;
  assign m_keep_in  = pay_active ? sel_pay_keep : '0;
  assign m_last_in  = pay_active & sel_last;

  always_comb begin
    s_ready_insert = '0;
    s_ready_in     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == ID_WD'(i)) begin
        s_ready_insert[i] = hdr_active & m_ready_insert;
        s_ready_in[i]     = pay_active & m_ready_in;
      end
    end
  end

  assign busy = (state == GRANT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic hdr_hs;
  logic last_hs;

  assign hdr_hs  = m_valid_insert & m_ready_insert;
  assign last_hs = m_valid_in & m_ready_in & m_last_in;

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_id;
    ptr_nxt       = ptr;
    hdr_done_nxt  = hdr_done;
    last_done_nxt = last_done;

    unique case (state)
      IDLE: begin
        if (req_found) begin
          state_nxt     = GRANT;
          grant_nxt     = req_winner;
          hdr_done_nxt  = 1'b0;
          last_done_nxt = 1'b0;
        end
      end

      GRANT: begin
        if (hdr_hs)  hdr_done_nxt  = 1'b1;
        if (last_hs) last_done_nxt = 1'b1;
        // Both halves of the frame are finished, even if they finished in the
        // same cycle. Release the grant and start the next search after it.
        if (hdr_done_nxt && last_done_nxt) begin
          state_nxt = IDLE;
          ptr_nxt   = (grant_id == ID_WD'(NUM_SRC - 1)) ? '0
                                                        : grant_id + ID_WD'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All of them then
  // update together at the edge from values sampled before it, whatever order
  // the simulator runs the processes in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      hdr_done  <= 1'b0;
      last_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_id  <= grant_nxt;
      hdr_done  <= hdr_done_nxt;
      last_done <= last_done_nxt;
    end
  end

endmodule

// File: doc/axis_insert_header_arbiter.md
# axis_insert_header_arbiter

Round-robin arbiter that shares one `axi_stream_insert_header` instance between `NUM_SRC` frame sources. Each source has a header channel and a payload channel. The arbiter grants one source per frame and routes both of its channels to the inserter's `*_insert` and `*_in` ports. It holds the grant until the frame's last payload beat is accepted. It sits directly upstream of the inserter, in the same clock domain.

## Interface
Parameters:
- `DATA_WD`, 64, payload/header width in bits
- `DATA_BYTE_WD`, `DATA_WD/8`, keep width
- `NUM_SRC`, 4, number of sources (2..8); `ID_WD = $clog2(NUM_SRC)`

Ports (source buses are flattened, source i occupies slice i):
- `clk`  in  1  the block's one clock
- `rst`  in  1  one clock; reset is synchronous and active-high
- `s_valid_insert`  in  NUM_SRC  header valid per source; this is also the frame request
- `s_header_insert`  in  NUM_SRC*DATA_WD  header data
- `s_keep_insert`  in  NUM_SRC*DATA_BYTE_WD  header keep
- `s_ready_insert`  out  NUM_SRC  header ready
- `s_valid_in`  in  NUM_SRC  payload valid
- `s_data_in`  in  NUM_SRC*DATA_WD  payload data
- `s_keep_in`  in  NUM_SRC*DATA_BYTE_WD  payload keep
- `s_last_in`  in  NUM_SRC  payload last
- `s_ready_in`  out  NUM_SRC  payload ready
- `m_valid_insert`, `m_header_insert`, `m_keep_insert`  out  1/DATA_WD/DATA_BYTE_WD  to inserter header port
- `m_ready_insert`  in  1  from inserter
- `m_valid_in`, `m_data_in`, `m_keep_in`, `m_last_in`  out  1/DATA_WD/DATA_BYTE_WD/1  to inserter payload port
- `m_ready_in`  in  1  from inserter
- `grant_id`  out  ID_WD  currently or last granted source
- `busy`  out  1  high while a grant is held

## Operation
- Two states, IDLE and GRANT.
- Registered: state, `grant_id`, RR pointer `ptr`, `hdr_done`, `last_done`.
- **IDLE**
  - The request vector is `s_valid_insert`.
  - Search order is `ptr`, `ptr+1`, … modulo `NUM_SRC`; the first set bit wins.
  - At the clock edge, the winner is loaded into `grant_id`, `hdr_done` and `last_done` are cleared, and state goes to GRANT.
  - With no request, the block stays in IDLE.
- **GRANT**, with g = `grant_id`:
  - Header path, while `hdr_done=0`: `m_*_insert` = source g's header fields; `s_ready_insert[g]` = `m_ready_insert`.
  - Header path, once `hdr_done=1`: `m_valid_insert=0` and `s_ready_insert[g]=0`. Only one header is passed per frame.
  - Payload path, while `last_done=0`: `m_*_in` = source g's payload fields; `s_ready_in[g]` = `m_ready_in`.
  - `hdr_done` sets on the `m_valid_insert & m_ready_insert` handshake.
  - `last_done` sets on the `m_valid_in & m_ready_in & m_last_in` handshake. Once it is set, the payload path is gated off (valid 0, ready 0).
  - When `hdr_done` and `last_done` are both set, including same-cycle sets: state returns to IDLE and `ptr` becomes `grant_id+1` (wrapping).
- Non-granted sources, and every source while in IDLE, see `s_ready_insert=0` and `s_ready_in=0`.
- All `m_*` outputs are combinational muxes of registered `grant_id`/state. `m_valid_*` is forced to 0 in IDLE. Data fields in IDLE are don't-care and are driven 0.
- A payload beat without a pending header request is never granted; it waits.
- `busy` = (state == GRANT).

## Timing
- Reset values: state IDLE, `ptr=0`, `grant_id=0`, `hdr_done=0`, `last_done=0`, `busy=0`. All `m_valid_*` and all `s_ready_*` are 0. All `m_` data, keep and last outputs are 0.
- Grant latency: a request visible in IDLE before edge k gives GRANT from edge k, so `m_valid_insert` is high in the cycle after edge k.
- Frame turnaround: the edge that completes the frame enters IDLE. The next frame can be granted at the following edge, so frames are separated by exactly one idle cycle.
- AXI rules hold on both `m_` channels: once valid is asserted with ready low, payload and valid stay stable. This follows from source compliance plus a grant that is fixed for the whole frame.
- Zero added latency on data: this is a pure mux, and ready passes straight through combinationally.
- Reset mid-frame: at the reset edge all state clears. From the next cycle every valid and ready is 0 and the partial frame is abandoned. The inserter shares `rst`. After reset, source 0 has top priority.

## Test plan
- Single frame, source 0:
  - Stimulus: header 0x1122334455667788 with keep 0x07, then 5 payload beats. The last beat has keep 0xE0.
  - Response: `m_` ports mirror source 0 beat for beat and `grant_id=0`. `busy` drops on the edge after the last handshake, then one idle cycle follows.
- All 4 sources request at once from reset, 3-beat frames each -> grants in the order 0,1,2,3, with exactly one idle cycle between frames.
- Sources 1 and 3 request continuously -> grants alternate 1,3,1,3. Sources 0 and 2 stay at ready 0 throughout.
- `m_ready_in` toggles 1,0,1,0 during a 5-beat frame -> all 5 beats are delivered once, in order, with data held stable while ready=0.
- Source 2 presents a second header during its own frame -> `s_ready_insert[2]` stays 0 after the first header handshake. The second header is granted only after `last_in` and the idle cycle.
- `rst` pulsed for 1 cycle at payload beat 3 of source 1 -> from the next cycle all valids are 0 and `busy=0`. With sources 1 and 0 then requesting, source 0 is granted first.
